pci_bus_arbiter: RTL and testbench

//  - Central PCI bus arbiter. Shares the Frame/AddressData/CBE/Irdy bus among NUM_MASTERS initiators.
//  - The PCI target is one of the devices on that bus.
//  - Takes active-low REQ lines and drives active-low GNT lines; monitors Frame/Irdy for bus-idle.
//  - Fair round-robin with one-cycle turnaround between owners.

---
 rtl/pci_arb_pkg.sv | 29 ++
 rtl/pci_rr_picker.sv | 42 ++++
 rtl/pci_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
// Holds the one-hot arbiter state encoding, the "no grant" pattern, the
// default revocation timeout used when PCI_ARB_TIMEOUT_EN is defined, and a
// small round-robin index helper.
package pci_arb_pkg;

  // Largest supported initiator count; GNT_NONE is sliced down from this.
  localparam int MAX_MASTERS = 8;

  // Idle cycles tolerated after a grant before it is revoked.
  localparam int DEF_TIMEOUT = 16;

  // Active-low grant bus with nobody granted.
  localparam logic [MAX_MASTERS-1:0] GNT_NONE = '1;

  // One-hot arbiter states.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    GRANT = 4'b0010,
    BUSY  = 4'b0100,
    TURN  = 4'b1000
  } arb_state_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker.
// Returns the first asserted (active-high) request at or after ptr,
// wrapping from NUM_MASTERS-1 back to 0, and whether any request exists.
module pci_rr_picker
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]     ptr,
  output logic [OWNER_W-1:0]     winner,
  output logic                   valid
);

  // Candidate index at each offset from the pointer, and whether it requests.
  logic [OWNER_W:0]       sum  [NUM_MASTERS];
  logic [OWNER_W-1:0]     cand [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] hit;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    // One extra bit holds ptr+offset before the modulo wrap.
    assign sum[gi]  = {1'b0, ptr} + (OWNER_W+1)'(gi);
    assign cand[gi] = (sum[gi] >= (OWNER_W+1)'(NUM_MASTERS))
                    ? OWNER_W'(sum[gi] - (OWNER_W+1)'(NUM_MASTERS))
                    : OWNER_W'(sum[gi]);
    assign hit[gi]  = req[cand[gi]];
  end

  assign valid = |req;

  // Scan offsets from far to near so the nearest hit is the one that sticks.
  always_comb begin
    winner = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner = cand[k];
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: fair round-robin over active-low REQ lines,
// active-low GNT outputs, one turnaround cycle between owners, hidden
// pre-emption of a busy owner when someone else is waiting.
// Optional feature macro: PCI_ARB_TIMEOUT_EN -- revokes a grant that has
// not been used (Frame never asserted) within TIMEOUT cycles.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   Clock,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] Req,
  input  logic                   Frame,
  input  logic                   Irdy,
  output logic [NUM_MASTERS-1:0] Gnt,
  output logic [OWNER_W-1:0]     Owner,
  output logic                   BusIdle
);

  localparam logic [NUM_MASTERS-1:0] GNT_IDLE = GNT_NONE[NUM_MASTERS-1:0];
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  arb_state_t             state_reg;
  logic [NUM_MASTERS-1:0] reqq;
  logic [OWNER_W-1:0]     ptr_reg;

  logic                   bus_idle;
  logic                   frame_act;
  logic [NUM_MASTERS-1:0] req_act;
  logic [NUM_MASTERS-1:0] owner_mask;
  logic                   owner_req;
  logic                   other_req;
  logic [OWNER_W-1:0]     pick_winner;
  logic                   pick_valid;
  logic [OWNER_W-1:0]     winner_next;

  // Only a hard 0 counts as asserted on Frame/Irdy; z or x reads as released.
  assign bus_idle  = (Frame !== 1'b0) && (Irdy !== 1'b0);
  assign frame_act = (Frame === 1'b0);

  assign req_act     = ~reqq;
  assign owner_mask  = ONE_HOT0 << Owner;
  assign owner_req   = req_act[Owner];
  assign other_req   = |(req_act & ~owner_mask);
  assign winner_next = OWNER_W'(rr_next(int'(pick_winner), NUM_MASTERS));

  pci_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .OWNER_W     (OWNER_W)
  ) u_picker (
    .req    (req_act),
    .ptr    (ptr_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef PCI_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TO_W-1:0] to_cnt_reg;
`else
  // No revocation hardware; TIMEOUT only keeps both builds on one parameter list.
  if (TIMEOUT > 0) begin : g_timeout_unused
  end
`endif

  // Input sampling: one register stage on Req, bus-idle history for BusIdle.
  always_ff @(posedge Clock) begin
    if (RST) begin
      reqq    <= GNT_IDLE;
      BusIdle <= 1'b1;
    end else begin
      reqq    <= Req;
      BusIdle <= bus_idle;
    end
  end

  // Arbitration FSM with registered Gnt/Owner, pointer and grant timeout.
  always_ff @(posedge Clock) begin
    if (RST) begin
      state_reg  <= IDLE;
      Gnt        <= GNT_IDLE;
      Owner      <= '0;
      ptr_reg    <= '0;
`ifdef PCI_ARB_TIMEOUT_EN
      to_cnt_reg <= '0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (pick_valid && bus_idle) begin
            Gnt       <= ~(ONE_HOT0 << pick_winner);
            Owner     <= pick_winner;
            ptr_reg   <= winner_next;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          // Frame beats a simultaneous request drop.
          if (frame_act) begin
            state_reg  <= BUSY;
`ifdef PCI_ARB_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
          end else if (!owner_req) begin
            Gnt        <= GNT_IDLE;
            state_reg  <= TURN;
`ifdef PCI_ARB_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
          end
`ifdef PCI_ARB_TIMEOUT_EN
          else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            Gnt        <= GNT_IDLE;
            ptr_reg    <= OWNER_W'(rr_next(int'(Owner), NUM_MASTERS));
            state_reg  <= TURN;
            to_cnt_reg <= '0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        BUSY: begin
          if (bus_idle) begin
            Gnt       <= GNT_IDLE;
            state_reg <= TURN;
          end else if (other_req) begin
            // Owner keeps the bus until it finishes, but loses the grant now.
            Gnt <= GNT_IDLE;
          end
        end
        TURN: begin
          Gnt       <= GNT_IDLE;
          state_reg <= IDLE;
        end
        default: begin
          Gnt       <= GNT_IDLE;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: directed scenarios followed by
// randomized masters, all compared every cycle against a behavioural model
// built from the arbitration rules (grant holder, transaction phase flags,
// modulo round-robin search). Define PCI_ARB_TIMEOUT_EN for both bench and
// RTL to exercise grant revocation.
module tb_pci_bus_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         RST;
  logic [N-1:0] Req;
  logic         Frame;
  logic         Irdy;
  logic [N-1:0] Gnt;
  logic [1:0]   Owner;
  logic         BusIdle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pci_bus_arbiter #(
    .NUM_MASTERS (N),
    .OWNER_W     (2),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .Clock   (clk),
    .RST     (RST),
    .Req     (Req),
    .Frame   (Frame),
    .Irdy    (Irdy),
    .Gnt     (Gnt),
    .Owner   (Owner),
    .BusIdle (BusIdle)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [N-1:0] m_req;      // sampled requests, active-high
  int           m_holder;   // master whose Gnt is low, -1 for none
  int           m_owner;
  int           m_ptr;
  bit           m_offered;  // granted, waiting for Frame
  bit           m_txn;      // transaction under way
  bit           m_turn;     // turnaround cycle
  bit           m_busidle;
`ifdef PCI_ARB_TIMEOUT_EN
  int           m_wait;
`endif
  logic [N-1:0] prev_gnt = '1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one rising edge using the pins as they stand.
  task automatic model_step();
    bit idle;
    bit fr;
    logic [N-1:0] others;
    if (RST) begin
      m_req = '0; m_holder = -1; m_owner = 0; m_ptr = 0;
      m_offered = 0; m_txn = 0; m_turn = 0; m_busidle = 1;
`ifdef PCI_ARB_TIMEOUT_EN
      m_wait = 0;
`endif
    end else begin
      idle = (Frame !== 1'b0) && (Irdy !== 1'b0);
      fr   = (Frame === 1'b0);
      if (m_turn) begin
        m_turn = 0;
      end else if (m_txn) begin
        if (idle) begin
          m_txn = 0; m_turn = 1; m_holder = -1;
        end else begin
          others = m_req;
          others[m_owner] = 1'b0;
          if (others != 0) m_holder = -1;
        end
      end else if (m_offered) begin
        if (fr) begin
          m_offered = 0; m_txn = 1;
        end else if (!m_req[m_owner]) begin
          m_offered = 0; m_turn = 1; m_holder = -1;
        end
`ifdef PCI_ARB_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_offered = 0; m_turn = 1; m_holder = -1;
            m_ptr = (m_owner + 1) % N;
          end
        end
`endif
      end else if (m_req != 0 && idle) begin
        int w;
        bit found;
        w = 0; found = 0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (!found && m_req[idx]) begin
            found = 1; w = idx;
          end
        end
        m_holder = w; m_owner = w; m_ptr = (w + 1) % N; m_offered = 1;
`ifdef PCI_ARB_TIMEOUT_EN
        m_wait = 0;
`endif
      end
      m_busidle = idle;
      m_req = ~Req;
    end
  endtask

  // One clock: update model at the edge, compare outputs at the falling edge.
  task automatic tick();
    logic [N-1:0] exp_gnt;
    logic [N-1:0] one;
    bit bad_switch;
    one = 1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    exp_gnt = (m_holder < 0) ? '1 : ~(one << m_holder);
    chk("gnt", Gnt, exp_gnt);
    chk("owner", Owner, m_owner);
    chk("busidle", BusIdle, m_busidle);
    chk("gnt_single", ($countones(~Gnt) <= 1), 1);
    bad_switch = (prev_gnt != '1) && (Gnt != '1) && (Gnt != prev_gnt);
    chk("gnt_no_turnaround", bad_switch, 0);
    if (prev_gnt == '1 && Gnt != '1)
      $display("grant Gnt=%b owner=%0d cycle=%0d", Gnt, Owner, cyc);
    prev_gnt = Gnt;
  endtask

  task automatic wait_grant(input logic [N-1:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (Gnt !== want && n < budget) begin
      tick();
      n++;
    end
    chk(tag, Gnt, want);
  endtask

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] want;
    logic [N-1:0] flip;
    bit in_txn;
    int phases;
    one = 1;

    // 1. Reset and a single master.
    RST = 1; Req = '1; Frame = 1; Irdy = 1;
    tick(); tick();
    chk("reset_gnt", Gnt, 4'b1111);
    chk("reset_busidle", BusIdle, 1);
    chk("reset_owner", Owner, 0);
    RST = 0; Req = 4'b1110;
    tick();
    chk("single_latency1", Gnt, 4'b1111);
    tick();
    chk("single_grant", Gnt, 4'b1110);
    chk("single_owner", Owner, 0);
    Frame = 0; tick();
    chk("single_busy", Gnt, 4'b1110);
    Frame = 1; Irdy = 0; Req = '1; tick();
    chk("single_data", Gnt, 4'b1110);
    Irdy = 1; tick();
    chk("single_turn", Gnt, 4'b1111);
    tick();
    chk("single_idle", Gnt, 4'b1111);

    // 2. Round-robin with everyone requesting.
    RST = 1; tick();
    RST = 0; Req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      want = ~(one << (k % N));
      wait_grant(want, 12, "rr_order");
      chk("rr_owner", Owner, k % N);
      Frame = 0; Irdy = 1; tick();
      Frame = 1; Irdy = 0; tick();
      Irdy = 1; tick();
    end

    // 3. Hidden pre-emption of a busy master 1 by master 3.
    RST = 1; Req = 4'b1101; tick();
    RST = 0; tick(); tick();
    chk("pre_grant1", Gnt, 4'b1101);
    Frame = 0; Irdy = 1; tick();
    chk("pre_busy", Gnt, 4'b1101);
    Irdy = 0; Req = 4'b0101; tick();
    chk("pre_sampling", Gnt, 4'b1101);
    Frame = 1; tick();
    chk("pre_release", Gnt, 4'b1111);
    Irdy = 1; Req = 4'b0111; tick();
    chk("pre_turn", Gnt, 4'b1111);
    tick();
    chk("pre_idle", Gnt, 4'b1111);
    tick();
    chk("pre_grant3", Gnt, 4'b0111);
    chk("pre_owner3", Owner, 3);

    // 4. Abandoned grants.
    Req = '1; tick();
    chk("abandon3_hold", Gnt, 4'b0111);
    tick();
    chk("abandon3_release", Gnt, 4'b1111);
    tick();
    Req = 4'b1011; tick(); tick();
    chk("abandon2_grant", Gnt, 4'b1011);
    chk("abandon2_owner", Owner, 2);
    Req = '1; tick();
    chk("abandon2_hold", Gnt, 4'b1011);
    tick();
    chk("abandon2_release", Gnt, 4'b1111);
    Req = 4'b0110; tick();
    chk("abandon2_turn", Gnt, 4'b1111);
    tick();
    chk("abandon2_ptr3", Gnt, 4'b0111);
    Req = '1; tick(); tick(); tick();

    // 5. Unused grant: revoked with the timeout, held forever without it.
    RST = 1; Req = 4'b1100; tick();
    RST = 0; tick(); tick();
    chk("to_grant0", Gnt, 4'b1110);
`ifdef PCI_ARB_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    chk("to_before", Gnt, 4'b1110);
    tick();
    chk("to_revoke", Gnt, 4'b1111);
    tick(); tick();
    chk("to_next1", Gnt, 4'b1101);
`else
    for (int k = 0; k < 100; k++) tick();
    chk("to_hold100", Gnt, 4'b1110);
`endif
    Req = '1; tick(); tick(); tick();

    // 6. Reset in the middle of a transaction.
    Req = 4'b1101;
    wait_grant(4'b1101, 12, "rst_pre_grant");
    Frame = 0; Irdy = 1; tick();
    Irdy = 0; tick();
    RST = 1; tick();
    chk("rst_mid_gnt", Gnt, 4'b1111);
    chk("rst_mid_owner", Owner, 0);
    chk("rst_mid_busidle", BusIdle, 1);
    RST = 0; Frame = 1; Irdy = 1; Req = 4'b1101; tick();
    chk("rst_after1", Gnt, 4'b1111);
    tick();
    chk("rst_after_grant", Gnt, 4'b1101);
    chk("rst_after_owner", Owner, 1);

    // Randomized masters against the model.
    in_txn = 0; phases = 0;
    for (int c = 0; c < 900; c++) begin
      flip = N'($urandom) & N'($urandom) & N'($urandom);
      Req = Req ^ flip;
      RST = ($urandom_range(0, 119) == 0);
      if (RST) begin
        in_txn = 0; Frame = 1; Irdy = 1;
      end else if (in_txn) begin
        if (phases > 1) begin
          Frame = 0; Irdy = 0; phases--;
        end else if (phases == 1) begin
          Frame = 1; Irdy = 0; phases = 0;
        end else begin
          Frame = 1; Irdy = 1; in_txn = 0;
        end
      end else if (Gnt != '1 && $urandom_range(0, 3) != 0) begin
        Frame = 0; Irdy = 1; in_txn = 1; phases = $urandom_range(1, 3);
      end else begin
        Frame = 1; Irdy = 1;
      end
      tick();
    end

    RST = 0; Req = '1; Frame = 1; Irdy = 1;
    repeat (6) tick();
    chk("final_quiet", Gnt, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
